// File: rtl/pipeline_types.sv
// Shared bus types, responder FSM states and byte-merge helper for the test SoC memory side.
package pipeline_types;

  typedef logic [31:0]  bus32_t;
  typedef logic [255:0] bus256_t;

  typedef enum logic [2:0] {IDLE, LRD, LWR, URD, UWR} dmem_state_t;

  localparam int DMEM_LINE_WORDS = 8;

  function automatic bus32_t merge_bytes(input bus32_t old_w, input bus32_t new_w,
                                         input logic [3:0] strb);
    bus32_t res;
    res = old_w;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) res[8*b +: 8] = new_w[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/dmem_lfsr_delay.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11) producing a 0..7 extra-latency value.
// Steps once per accepted request; the value seen at accept is the one applied.
module dmem_lfsr_delay (
  input  logic       clk,
  input  logic       rst,
  input  logic       advance,
  output logic [2:0] delay
);

  logic [15:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (advance) lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end

  always_ff @(posedge clk) begin
    if (rst) lfsr_q <= 16'hACE1;
    else     lfsr_q <= lfsr_d;
  end

  assign delay = lfsr_q[2:0];

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding memory responder: line refill/writeback plus uncached word ports, fixed latency
// (READ_LAT / WRITE_LAT); busy = rd_rdy/wr_rdy low. DMEM_RAND_LATENCY_EN adds 0..7 cycles per request.
module dmem_responder
  import pipeline_types::*;
#(
  parameter int    DEPTH_WORDS = 65536,
  parameter int    READ_LAT    = 4,
  parameter int    WRITE_LAT   = 2,
  parameter string INIT_FILE   = ""
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rd_req,
  input  logic [31:0]   rd_addr,
  output logic          rd_rdy,
  output logic [255:0]  ret_data,
  output logic          ret_valid,
  input  logic          wr_req,
  input  logic [31:0]   wr_addr,
  input  logic [3:0]    wr_wstrb,
  input  logic [255:0]  wr_data,
  output logic          wr_rdy,
  input  logic          ducache_ren_i,
  input  logic [31:0]   ducache_araddr_i,
  output logic          ducache_rvalid_o,
  output logic [31:0]   ducache_rdata_o,
  input  logic          ducache_wen_i,
  input  logic [31:0]   ducache_awaddr_i,
  input  logic [31:0]   ducache_wdata_i,
  input  logic [3:0]    ducache_strb,
  output logic          ducache_bvalid_o
);

  localparam int IW     = $clog2(DEPTH_WORDS);
  localparam int MAXLAT = (READ_LAT > WRITE_LAT) ? READ_LAT : WRITE_LAT;
  localparam int CW     = $clog2(MAXLAT + 8);
  localparam logic [CW-1:0] RD_LOAD = CW'(READ_LAT - 1);
  localparam logic [CW-1:0] WR_LOAD = CW'(WRITE_LAT - 1);

  typedef logic [IW-1:0] idx_t;

  function automatic idx_t line_word(input idx_t base, input int k);
    return {base[IW-1:3], 3'(k)};
  endfunction

  bus32_t mem [DEPTH_WORDS];

  dmem_state_t   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  idx_t          addr_q, addr_d;
  bus256_t       ret_data_q, ret_data_d;
  logic          ret_valid_q, ret_valid_d;
  bus32_t        rdata_q, rdata_d;
  logic          rvalid_q, rvalid_d;
  logic          bvalid_q, bvalid_d;
  bus256_t       rd_line;

  idx_t rd_idx, wr_idx, ur_idx, uw_idx;
  assign rd_idx = rd_addr[IW+1:2];
  assign wr_idx = wr_addr[IW+1:2];
  assign ur_idx = ducache_araddr_i[IW+1:2];
  assign uw_idx = ducache_awaddr_i[IW+1:2];

  logic unused_addr_bits;
  assign unused_addr_bits = ^{rd_addr[31:IW+2], rd_addr[1:0], wr_addr[31:IW+2], wr_addr[1:0],
                              ducache_araddr_i[31:IW+2], ducache_araddr_i[1:0],
                              ducache_awaddr_i[31:IW+2], ducache_awaddr_i[1:0]};

  // Fixed-priority accept: wr_req > rd_req > ducache_wen_i > ducache_ren_i.
  logic idle, acc_lwr, acc_lrd, acc_uwr, acc_urd, accept;
  assign idle    = (state_q == IDLE) && !rst;
  assign acc_lwr = idle && wr_req;
  assign acc_lrd = idle && !wr_req && rd_req;
  assign acc_uwr = idle && !wr_req && !rd_req && ducache_wen_i;
  assign acc_urd = idle && !wr_req && !rd_req && !ducache_wen_i && ducache_ren_i;
  assign accept  = acc_lwr | acc_lrd | acc_uwr | acc_urd;

  logic [2:0] extra;
`ifdef DMEM_RAND_LATENCY_EN
  dmem_lfsr_delay u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .advance (accept),
    .delay   (extra)
  );
`else
  assign extra = 3'd0;
`endif

  always_comb begin
    rd_line = '0;
    for (int k = 0; k < DMEM_LINE_WORDS; k++) rd_line[32*k +: 32] = mem[line_word(addr_q, k)];
  end

  // Read states hold for the pulse cycle so a held ducache_ren_i is not re-accepted.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    ret_data_d  = ret_data_q;
    ret_valid_d = 1'b0;
    rdata_d     = rdata_q;
    rvalid_d    = 1'b0;
    bvalid_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (acc_lwr) begin
          state_d = LWR; cnt_d = WR_LOAD + CW'(extra); addr_d = wr_idx;
        end else if (acc_lrd) begin
          state_d = LRD; cnt_d = RD_LOAD + CW'(extra); addr_d = rd_idx;
        end else if (acc_uwr) begin
          state_d = UWR; cnt_d = WR_LOAD + CW'(extra); addr_d = uw_idx;
        end else if (acc_urd) begin
          state_d = URD; cnt_d = RD_LOAD + CW'(extra); addr_d = ur_idx;
        end
      end
      LRD: begin
        if (ret_valid_q)        state_d = IDLE;
        else if (cnt_q != '0)   cnt_d = cnt_q - 1'b1;
        else begin
          ret_valid_d = 1'b1;
          ret_data_d  = rd_line;
        end
      end
      LWR: begin
        if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
        else             state_d = IDLE;
      end
      URD: begin
        if (rvalid_q)           state_d = IDLE;
        else if (cnt_q != '0)   cnt_d = cnt_q - 1'b1;
        else begin
          rvalid_d = 1'b1;
          rdata_d  = mem[addr_q];
        end
      end
      UWR: begin
        if (bvalid_q)           state_d = IDLE;
        else if (cnt_q != '0)   cnt_d = cnt_q - 1'b1;
        else                    bvalid_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      ret_data_q  <= '0;
      ret_valid_q <= 1'b0;
      rdata_q     <= '0;
      rvalid_q    <= 1'b0;
      bvalid_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      ret_data_q  <= ret_data_d;
      ret_valid_q <= ret_valid_d;
      rdata_q     <= rdata_d;
      rvalid_q    <= rvalid_d;
      bvalid_q    <= bvalid_d;
    end
  end

  // Writes commit on the accept edge; storage has no reset.
  always_ff @(posedge clk) begin
    if (acc_lwr) begin
      if (wr_wstrb == 4'hF) begin
        for (int k = 0; k < DMEM_LINE_WORDS; k++) mem[line_word(wr_idx, k)] <= wr_data[32*k +: 32];
      end else begin
        mem[wr_idx] <= merge_bytes(mem[wr_idx], wr_data[31:0], wr_wstrb);
      end
    end else if (acc_uwr) begin
      mem[uw_idx] <= merge_bytes(mem[uw_idx], ducache_wdata_i, ducache_strb);
    end
  end

  assign rd_rdy           = (state_q == IDLE);
  assign wr_rdy           = (state_q == IDLE);
  assign ret_data         = ret_data_q;
  assign ret_valid        = ret_valid_q;
  assign ducache_rdata_o  = rdata_q;
  assign ducache_rvalid_o = rvalid_q;
  assign ducache_bvalid_o = bvalid_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed sequences, a vector table of uncached ops and a randomized
// run scored against an associative-array memory model.
module tb_dmem_responder;

  localparam int RL = 4;
  localparam int WL = 2;
  localparam int IW = 16;
`ifdef DMEM_RAND_LATENCY_EN
  localparam int SLACK = 7;
`else
  localparam int SLACK = 0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         rd_req, wr_req, ducache_ren_i, ducache_wen_i;
  logic [31:0]  rd_addr, wr_addr, ducache_araddr_i, ducache_awaddr_i, ducache_wdata_i;
  logic [3:0]   wr_wstrb, ducache_strb;
  logic [255:0] wr_data;
  logic         rd_rdy, wr_rdy, ret_valid, ducache_rvalid_o, ducache_bvalid_o;
  logic [255:0] ret_data;
  logic [31:0]  ducache_rdata_o;

  always #5 clk = ~clk;

  dmem_responder dut (
    .clk(clk), .rst(rst),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_rdy(rd_rdy),
    .ret_data(ret_data), .ret_valid(ret_valid),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_wstrb(wr_wstrb), .wr_data(wr_data), .wr_rdy(wr_rdy),
    .ducache_ren_i(ducache_ren_i), .ducache_araddr_i(ducache_araddr_i),
    .ducache_rvalid_o(ducache_rvalid_o), .ducache_rdata_o(ducache_rdata_o),
    .ducache_wen_i(ducache_wen_i), .ducache_awaddr_i(ducache_awaddr_i),
    .ducache_wdata_i(ducache_wdata_i), .ducache_strb(ducache_strb),
    .ducache_bvalid_o(ducache_bvalid_o)
  );

  int checks = 0;
  int errors = 0;

  bit [31:0] model [int];

  function automatic int widx(input bit [31:0] a);
    return int'(a[IW+1:2]);
  endfunction

  function automatic bit [31:0] merge(input bit [31:0] o, input bit [31:0] n, input bit [3:0] s);
    bit [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = n[8*b +: 8];
    return r;
  endfunction

  function automatic bit [255:0] m_line(input bit [31:0] a);
    bit [255:0] d;
    int base;
    base = widx(a) & ~7;
    for (int k = 0; k < 8; k++) d[32*k +: 32] = model[base + k];
    return d;
  endfunction

  task automatic m_line_wr(input bit [31:0] a, input bit [255:0] d, input bit [3:0] s);
    int base;
    base = widx(a) & ~7;
    if (s == 4'hF) for (int k = 0; k < 8; k++) model[base + k] = d[32*k +: 32];
    else model[widx(a)] = merge(model[widx(a)], d[31:0], s);
  endtask

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  task automatic chk_lat(input string name, input int lat, input int lo);
    checks++;
    if (lat < lo || lat > lo + SLACK) begin
      errors++;
      $display("FAIL %s latency got=%0d want=%0d..%0d", name, lat, lo, lo + SLACK);
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!wr_rdy && n < 64) begin @(negedge clk); n++; end
    if (!wr_rdy) begin
      checks++; errors++;
      $display("FAIL wait_idle got=busy want=idle within 64 cycles");
    end
  endtask

  task automatic line_wr(input bit [31:0] a, input bit [255:0] d, input bit [3:0] s, output int busy);
    wait_idle();
    wr_addr = a; wr_data = d; wr_wstrb = s; wr_req = 1'b1;
    @(posedge clk);
    m_line_wr(a, d, s);
    @(negedge clk);
    wr_req = 1'b0;
    busy = 0;
    while (!wr_rdy && busy < 64) begin busy++; @(negedge clk); end
  endtask

  task automatic line_rd(input bit [31:0] a, output bit [255:0] d, output int lat);
    wait_idle();
    rd_addr = a; rd_req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rd_req = 1'b0;
    lat = 0;
    while (!ret_valid && lat < 64) begin @(negedge clk); lat++; end
    d = ret_data;
    @(negedge clk);
  endtask

  task automatic ucd_rd(input bit [31:0] a, output bit [31:0] d, output int lat);
    wait_idle();
    ducache_araddr_i = a; ducache_ren_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    lat = 0;
    while (!ducache_rvalid_o && lat < 64) begin @(negedge clk); lat++; end
    d = ducache_rdata_o;
    ducache_ren_i = 1'b0;
  endtask

  task automatic ucd_wr(input bit [31:0] a, input bit [31:0] d, input bit [3:0] s, output int lat);
    wait_idle();
    ducache_awaddr_i = a; ducache_wdata_i = d; ducache_strb = s; ducache_wen_i = 1'b1;
    @(posedge clk);
    model[widx(a)] = merge(model[widx(a)], d, s);
    @(negedge clk);
    lat = 0;
    while (!ducache_bvalid_o && lat < 64) begin @(negedge clk); lat++; end
    ducache_wen_i = 1'b0;
  endtask

  typedef struct {
    bit        is_wr;
    bit [31:0] addr;
    bit [31:0] wdata;
    bit [3:0]  strb;
    bit [31:0] exp;
  } vec_t;

  initial begin
    vec_t         tbl [9];
    bit [255:0]   l1, l2, l3, d, rnd;
    bit [31:0]    w, a;
    bit [3:0]     s;
    int           lat, busy, kind;
    bit           seen;

    tbl[0] = '{1'b1, 32'h0000_0020, 32'h0102_0304, 4'hF, 32'h0};
    tbl[1] = '{1'b1, 32'h0000_0020, 32'hAB00_0000, 4'h8, 32'h0};
    tbl[2] = '{1'b0, 32'h0000_0020, 32'h0,         4'h0, 32'hAB02_0304};
    tbl[3] = '{1'b1, 32'h0000_0024, 32'hFFFF_FFFF, 4'hF, 32'h0};
    tbl[4] = '{1'b1, 32'h0000_0024, 32'h0000_0000, 4'h5, 32'h0};
    tbl[5] = '{1'b0, 32'h0000_0024, 32'h0,         4'h0, 32'hFF00_FF00};
    tbl[6] = '{1'b0, 32'h0004_0020, 32'h0,         4'h0, 32'hAB02_0304};
    tbl[7] = '{1'b1, 32'hFFFC_0024, 32'h1234_5678, 4'h2, 32'h0};
    tbl[8] = '{1'b0, 32'h0000_0024, 32'h0,         4'h0, 32'hFF00_5600};

    rst = 1'b1;
    rd_req = 1'b0; wr_req = 1'b0; ducache_ren_i = 1'b0; ducache_wen_i = 1'b0;
    rd_addr = '0; wr_addr = '0; wr_wstrb = '0; wr_data = '0;
    ducache_araddr_i = '0; ducache_awaddr_i = '0; ducache_wdata_i = '0; ducache_strb = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset_rd_rdy", 256'(rd_rdy), 256'(1));
    chk("reset_wr_rdy", 256'(wr_rdy), 256'(1));
    chk("reset_valids", 256'({ret_valid, ducache_rvalid_o, ducache_bvalid_o}), 256'(0));
    chk("reset_ret_data", ret_data, 256'(0));
    chk("reset_rdata", 256'(ducache_rdata_o), 256'(0));

    // Full line write then refill from a different word of the same line.
    for (int k = 0; k < 8; k++) l1[32*k +: 32] = 32'h1111_1111 * (k + 1);
    line_wr(32'h100, l1, 4'hF, busy);
    chk_lat("t1_wr_busy", busy, WL);
    line_rd(32'h104, d, lat);
    chk_lat("t1_rd_lat", lat, RL);
    chk("t1_rd_data", d, l1);
    chk("t1_pulse_single", 256'(ret_valid), 256'(0));
    chk("t1_data_hold", ret_data, l1);

    // Partial line write merges into one word only.
    line_wr(32'h108, {224'h0, 32'hDEAD_BEEF}, 4'b0011, busy);
    chk_lat("t2_wr_busy", busy, WL);
    ucd_rd(32'h108, w, lat);
    chk("t2_ucd_data", 256'(w), 256'(32'h3333_BEEF));
    chk_lat("t2_ucd_lat", lat, RL);
    l2 = l1;
    l2[95:64] = 32'h3333_BEEF;
    line_rd(32'h100, d, lat);
    chk("t2_line_data", d, l2);

    // Uncached vectors: strobes, aliasing of upper address bits.
    foreach (tbl[i]) begin
      if (tbl[i].is_wr) begin
        ucd_wr(tbl[i].addr, tbl[i].wdata, tbl[i].strb, lat);
        chk_lat($sformatf("vec%0d_bvalid_lat", i), lat, WL);
      end else begin
        ucd_rd(tbl[i].addr, w, lat);
        chk($sformatf("vec%0d_rdata", i), 256'(w), 256'(tbl[i].exp));
        chk_lat($sformatf("vec%0d_rvalid_lat", i), lat, RL);
      end
    end

    // Three requesters in one IDLE cycle: line write, then refill, then uncached write.
    for (int k = 0; k < 8; k++) l3[32*k +: 32] = 32'hC0DE_0000 + 32'(k);
    wait_idle();
    wr_addr = 32'h300; wr_data = l3; wr_wstrb = 4'hF; wr_req = 1'b1;
    rd_addr = 32'h300; rd_req = 1'b1;
    ducache_awaddr_i = 32'h304; ducache_wdata_i = 32'h5A5A_5A5A; ducache_strb = 4'hF;
    ducache_wen_i = 1'b1;
    @(posedge clk);
    m_line_wr(32'h300, l3, 4'hF);
    @(negedge clk);
    wr_req = 1'b0;
    chk("t3_rd_blocked", 256'(rd_rdy), 256'(0));
    busy = 0;
    while (!rd_rdy && busy < 64) begin busy++; @(negedge clk); end
    chk_lat("t3_wr_busy", busy, WL);
    @(posedge clk);
    @(negedge clk);
    rd_req = 1'b0;
    seen = 1'b0;
    lat = 0;
    while (!ret_valid && lat < 64) begin
      @(negedge clk); lat++;
      if (ducache_bvalid_o) seen = 1'b1;
    end
    chk_lat("t3_rd_lat", lat, RL);
    chk("t3_rd_data", ret_data, l3);
    chk("t3_no_bvalid_before_read", 256'(seen), 256'(0));
    lat = 0;
    while (!ducache_bvalid_o && lat < 64) begin @(negedge clk); lat++; end
    ducache_wen_i = 1'b0;
    model[widx(32'h304)] = 32'h5A5A_5A5A;
    chk_lat("t3_bvalid_lat", lat, WL + 2);
    ucd_rd(32'h304, w, lat);
    chk("t3_ucd_data", 256'(w), 256'(32'h5A5A_5A5A));

    // Reset two cycles into a refill: the pulse must never appear.
    wait_idle();
    rd_addr = 32'h100; rd_req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rd_req = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t5_rd_rdy", 256'(rd_rdy), 256'(1));
    chk("t5_ret_data", ret_data, 256'(0));
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (ret_valid) seen = 1'b1;
    end
    chk("t5_no_ret_valid", 256'(seen), 256'(0));
    line_rd(32'h100, d, lat);
    chk("t5_mem_kept", d, l2);

    // Randomized traffic over 16 lines with random aliasing bits.
    for (int l = 0; l < 16; l++) begin
      for (int k = 0; k < 8; k++) rnd[32*k +: 32] = $urandom;
      line_wr(32'h2000 + 32'(l * 32), rnd, 4'hF, busy);
    end
    for (int n = 0; n < 1000; n++) begin
      kind = $urandom_range(0, 3);
      a = (32'($urandom_range(0, 15)) << 18) | 32'h2000 |
          (32'($urandom_range(0, 15)) << 5) | (32'($urandom_range(0, 7)) << 2);
      s = 4'($urandom_range(0, 15));
      case (kind)
        0: begin
          for (int k = 0; k < 8; k++) rnd[32*k +: 32] = $urandom;
          if ($urandom_range(0, 1) == 1) s = 4'hF;
          line_wr(a, rnd, s, busy);
          chk_lat($sformatf("rnd%0d_lwr_busy", n), busy, WL);
        end
        1: begin
          line_rd(a, d, lat);
          chk($sformatf("rnd%0d_line", n), d, m_line(a));
          chk_lat($sformatf("rnd%0d_lrd_lat", n), lat, RL);
        end
        2: begin
          ucd_wr(a, $urandom, s, lat);
          chk_lat($sformatf("rnd%0d_uwr_lat", n), lat, WL);
        end
        default: begin
          ucd_rd(a, w, lat);
          chk($sformatf("rnd%0d_word", n), 256'(w), 256'(model[widx(a)]));
          chk_lat($sformatf("rnd%0d_urd_lat", n), lat, RL);
        end
      endcase
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
